// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage
// Brief   : ID/EX pipeline register with load-use hazard detection, bubble
//           insertion, flush/stall handling and a saturating bubble counter.
// Revision: 1.0 - initial release
// ============================================================================
module id_ex_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ctrl_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        alusrc_o,
    output logic [1:0]  aluop_o,
    output logic        regdst_o,
    output logic        memread_o,
    output logic        memwrite_o,
    output logic        regwrite_o,
    output logic        memtoreg_o,
    output logic [31:0] pc4_o,
    output logic [31:0] rs_data_o,
    output logic [31:0] rt_data_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic        valid_o,
    output logic        stall_o,
    output logic [15:0] bubble_cnt_o
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [7:0]  r_ctrl;
    logic [31:0] r_pc4;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_imm;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;
    logic        r_valid;
    logic [15:0] r_bubble_cnt;

    logic        w_haz;
    logic        w_unused_ctrl;

    // Load in EX whose destination feeds the instruction now in ID; $zero never hazards.
    assign w_haz = r_ctrl[4] & r_valid & (r_rt != 5'd0) &
                   ((r_rt == rs_i) | (r_rt == rt_i));

    assign stall_o       = w_haz & ~flush_i;
    assign w_unused_ctrl = ^ctrl_i[31:8];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ctrl       <= 8'd0;
            r_pc4        <= 32'd0;
            r_rs_data    <= 32'd0;
            r_rt_data    <= 32'd0;
            r_imm        <= 32'd0;
            r_rs         <= 5'd0;
            r_rt         <= 5'd0;
            r_rd         <= 5'd0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= 16'd0;
        end else if (stall_i) begin
            r_ctrl       <= r_ctrl;
        end else if (flush_i || w_haz) begin
            r_ctrl       <= 8'd0;
            r_pc4        <= 32'd0;
            r_rs_data    <= 32'd0;
            r_rt_data    <= 32'd0;
            r_imm        <= 32'd0;
            r_rs         <= 5'd0;
            r_rt         <= 5'd0;
            r_rd         <= 5'd0;
            r_valid      <= 1'b0;
            // Only hazard bubbles are counted; a flush takes precedence.
            if (!flush_i && (r_bubble_cnt != c_CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end else begin
            r_ctrl       <= ctrl_i[7:0];
            r_pc4        <= pc4_i;
            r_rs_data    <= rs_data_i;
            r_rt_data    <= rt_data_i;
            r_imm        <= imm_i;
            r_rs         <= rs_i;
            r_rt         <= rt_i;
            r_rd         <= rd_i;
            r_valid      <= 1'b1;
        end
    end

    assign alusrc_o     = r_ctrl[0];
    assign aluop_o      = r_ctrl[2:1];
    assign regdst_o     = r_ctrl[3];
    assign memread_o    = r_ctrl[4];
    assign memwrite_o   = r_ctrl[5];
    assign regwrite_o   = r_ctrl[6];
    assign memtoreg_o   = r_ctrl[7];
    assign pc4_o        = r_pc4;
    assign rs_data_o    = r_rs_data;
    assign rt_data_o    = r_rt_data;
    assign imm_o        = r_imm;
    assign rs_o         = r_rs;
    assign rt_o         = r_rt;
    assign rd_o         = r_rd;
    assign valid_o      = r_valid;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_stage
// Brief   : Table-driven self-checking bench for id_ex_stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk;
    logic        rst_i;
    logic [31:0] ctrl_i, pc4_i, rs_data_i, rt_data_i, imm_i;
    logic [4:0]  rs_i, rt_i, rd_i;
    logic        flush_i, stall_i;
    logic        alusrc_o, regdst_o, memread_o, memwrite_o, regwrite_o, memtoreg_o;
    logic [1:0]  aluop_o;
    logic [31:0] pc4_o, rs_data_o, rt_data_o, imm_o;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic        valid_o, stall_o;
    logic [15:0] bubble_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    id_ex_stage dut (
        .clk_i(clk), .rst_i(rst_i), .ctrl_i(ctrl_i), .pc4_i(pc4_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .flush_i(flush_i), .stall_i(stall_i),
        .alusrc_o(alusrc_o), .aluop_o(aluop_o), .regdst_o(regdst_o),
        .memread_o(memread_o), .memwrite_o(memwrite_o), .regwrite_o(regwrite_o),
        .memtoreg_o(memtoreg_o), .pc4_o(pc4_o), .rs_data_o(rs_data_o),
        .rt_data_o(rt_data_o), .imm_o(imm_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o),
        .valid_o(valid_o), .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // One row = one rising edge. Datapath words derive from dat:
    // pc4 = dat<<2, rs_data = dat*3, rt_data = dat*5, imm = dat (a bubble gives all 0).
    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [31:0] ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] dat;
        logic        chk_st;
        logic        e_st;
        logic [7:0]  e_ctrl;
        logic        e_valid;
        logic [4:0]  e_rs;
        logic [4:0]  e_rt;
        logic [4:0]  e_rd;
        logic [31:0] e_dat;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [7:0] w_ctrl;
        @(negedge clk);
        rst_i     = v.rst;
        stall_i   = v.stall;
        flush_i   = v.flush;
        ctrl_i    = v.ctrl;
        rs_i      = v.rs;
        rt_i      = v.rt;
        rd_i      = v.rd;
        pc4_i     = v.dat << 2;
        rs_data_i = v.dat * 32'd3;
        rt_data_i = v.dat * 32'd5;
        imm_i     = v.dat;
        #1;
        if (v.chk_st) chk($sformatf("row%0d stall_o", idx), {31'd0, stall_o}, {31'd0, v.e_st});
        @(posedge clk);
        #1;
        w_ctrl = {memtoreg_o, regwrite_o, memwrite_o, memread_o, regdst_o, aluop_o, alusrc_o};
        chk($sformatf("row%0d ctrl", idx),    {24'd0, w_ctrl},       {24'd0, v.e_ctrl});
        chk($sformatf("row%0d valid", idx),   {31'd0, valid_o},      {31'd0, v.e_valid});
        chk($sformatf("row%0d rs_o", idx),    {27'd0, rs_o},         {27'd0, v.e_rs});
        chk($sformatf("row%0d rt_o", idx),    {27'd0, rt_o},         {27'd0, v.e_rt});
        chk($sformatf("row%0d rd_o", idx),    {27'd0, rd_o},         {27'd0, v.e_rd});
        chk($sformatf("row%0d pc4", idx),     pc4_o,                 v.e_dat << 2);
        chk($sformatf("row%0d rs_data", idx), rs_data_o,             v.e_dat * 32'd3);
        chk($sformatf("row%0d rt_data", idx), rt_data_o,             v.e_dat * 32'd5);
        chk($sformatf("row%0d imm", idx),     imm_o,                 v.e_dat);
        chk($sformatf("row%0d bubble_cnt", idx), {16'd0, bubble_cnt_o}, {16'd0, v.e_cnt});
    endtask

    initial begin
        vec_t v_lw;
        vec_t v_use;
        vec_t v_sat;

        //            rst stl fl  ctrl          rs rt rd dat       chk est ectrl  ev ers ert erd edat      ecnt
        vecs[0]  = '{1'b0,1'b1,1'b0,32'h0000004D,1, 2, 3, 32'h11, 1'b0,1'b0,8'h00,1'b0,0,0, 0, 32'h00, 16'd0};
        vecs[1]  = '{1'b1,1'b0,1'b0,32'h000000D1,2, 8, 0, 32'h04, 1'b1,1'b0,8'hD1,1'b1,2,8, 0, 32'h04, 16'd0};
        vecs[2]  = '{1'b1,1'b0,1'b0,32'h0000004C,8, 9,10, 32'h20, 1'b1,1'b1,8'h00,1'b0,0,0, 0, 32'h00, 16'd1};
        vecs[3]  = '{1'b1,1'b0,1'b0,32'h0000004C,8, 9,10, 32'h20, 1'b1,1'b0,8'h4C,1'b1,8,9,10, 32'h20, 16'd1};
        vecs[4]  = '{1'b1,1'b0,1'b0,32'h000000D1,3, 0, 0, 32'h08, 1'b1,1'b0,8'hD1,1'b1,3,0, 0, 32'h08, 16'd1};
        vecs[5]  = '{1'b1,1'b0,1'b0,32'hFFFFFF4C,0, 5, 6, 32'h30, 1'b1,1'b0,8'h4C,1'b1,0,5, 6, 32'h30, 16'd1};
        vecs[6]  = '{1'b1,1'b0,1'b0,32'h000000D1,1, 7, 0, 32'h40, 1'b1,1'b0,8'hD1,1'b1,1,7, 0, 32'h40, 16'd1};
        vecs[7]  = '{1'b1,1'b0,1'b1,32'h0000004C,2, 7, 3, 32'h50, 1'b1,1'b0,8'h00,1'b0,0,0, 0, 32'h00, 16'd1};
        vecs[8]  = '{1'b1,1'b0,1'b0,32'h000000D1,1, 7, 0, 32'h44, 1'b1,1'b0,8'hD1,1'b1,1,7, 0, 32'h44, 16'd1};
        vecs[9]  = '{1'b1,1'b1,1'b0,32'h0000004C,7, 2, 3, 32'h60, 1'b1,1'b1,8'hD1,1'b1,1,7, 0, 32'h44, 16'd1};
        vecs[10] = '{1'b1,1'b0,1'b0,32'h0000004C,7, 2, 3, 32'h60, 1'b1,1'b1,8'h00,1'b0,0,0, 0, 32'h00, 16'd2};
        vecs[11] = '{1'b1,1'b0,1'b0,32'h0000004C,7, 2, 3, 32'h60, 1'b1,1'b0,8'h4C,1'b1,7,2, 3, 32'h60, 16'd2};
        vecs[12] = '{1'b1,1'b0,1'b0,32'h00000021,4, 5, 0, 32'h70, 1'b1,1'b0,8'h21,1'b1,4,5, 0, 32'h70, 16'd2};
        vecs[13] = '{1'b1,1'b0,1'b0,32'h000000D1,4, 9, 0, 32'h80, 1'b1,1'b0,8'hD1,1'b1,4,9, 0, 32'h80, 16'd2};
        vecs[14] = '{1'b0,1'b1,1'b1,32'h0000004C,9, 1, 2, 32'h90, 1'b1,1'b0,8'h00,1'b0,0,0, 0, 32'h00, 16'd0};
        vecs[15] = '{1'b1,1'b0,1'b0,32'h0000004C,9, 1, 2, 32'h90, 1'b1,1'b0,8'h4C,1'b1,9,1, 2, 32'h90, 16'd0};
        vecs[16] = '{1'b1,1'b1,1'b0,32'h000000D1,1, 2, 0, 32'hA0, 1'b1,1'b0,8'h4C,1'b1,9,1, 2, 32'h90, 16'd0};
        vecs[17] = '{1'b1,1'b0,1'b1,32'h000000D1,1, 2, 0, 32'hA0, 1'b1,1'b0,8'h00,1'b0,0,0, 0, 32'h00, 16'd0};

        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; ctrl_i = 32'd0;
        pc4_i = 32'd0; rs_data_i = 32'd0; rt_data_i = 32'd0; imm_i = 32'd0;
        rs_i = 5'd0; rt_i = 5'd0; rd_i = 5'd0;

        for (int i = 0; i < 18; i++) apply(vecs[i], i);

        // Saturation: preset the counter just below the limit, then drive
        // alternating load / dependent-use pairs so each pair adds one bubble.
        v_lw  = '{1'b1,1'b0,1'b0,32'h000000D1,1,7,0,32'hB0, 1'b1,1'b0,8'hD1,1'b1,1,7,0,32'hB0,16'd0};
        v_use = '{1'b1,1'b0,1'b0,32'h0000004C,7,3,4,32'hC0, 1'b1,1'b1,8'h00,1'b0,0,0,0,32'h00,16'd0};
        apply(v_lw, 100);

        @(negedge clk);
        stall_i = 1'b1;
        force dut.r_bubble_cnt = 16'hFFFD;
        #1;
        release dut.r_bubble_cnt;
        #1;
        chk("sat preset", {16'd0, bubble_cnt_o}, 32'h0000FFFD);

        for (int k = 0; k < 3; k++) begin
            v_sat       = v_use;
            v_sat.e_cnt = (k == 0) ? 16'hFFFE : 16'hFFFF;
            apply(v_sat, 200 + 2 * k);
            v_sat       = v_lw;
            v_sat.e_cnt = (k == 0) ? 16'hFFFE : 16'hFFFF;
            apply(v_sat, 201 + 2 * k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
